// File: rtl/gemm_result_streamer.sv
// Snapshots result_matrix on istart and streams it row-major over a registered valid/ready port.
// Define GEMM_STREAM_CHECKSUM_EN to enable the running XOR checksum on ochecksum.
module gemm_result_streamer #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4,
    localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1,
    localparam int CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  istart,
    input  logic [DATA_WIDTH-1:0] result_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
    output logic                  ovalid,
    input  logic                  iready,
    output logic [DATA_WIDTH-1:0] odata,
    output logic [RW-1:0]         orow,
    output logic [CW-1:0]         ocol,
    output logic                  olast,
    output logic                  obusy,
    output logic                  odone,
    output logic [DATA_WIDTH-1:0] ochecksum
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
    logic [DATA_WIDTH-1:0] mem_d [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RW-1:0]         row_q, row_d, nrow_s;
    logic [CW-1:0]         col_q, col_d, ncol_s;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  xfer_s;

    assign xfer_s = valid_q && iready;

    // Row-major successor of the element currently presented.
    always_comb begin
        if (col_q == COL_LAST) begin
            ncol_s = {CW{1'b0}};
            nrow_s = row_q + RW'(1);
        end else begin
            ncol_s = col_q + CW'(1);
            nrow_s = row_q;
        end
    end

    // Next-state and next-output logic; outputs are precomputed so they leave as flops.
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    mem_d   = result_matrix;
                    data_d  = result_matrix[0][0];
                    row_d   = {RW{1'b0}};
                    col_d   = {CW{1'b0}};
                    valid_d = 1'b1;
                    last_d  = (ROW_LAST == {RW{1'b0}}) && (COL_LAST == {CW{1'b0}});
                    busy_d  = 1'b1;
                    state_d = S_STREAM;
                end else begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_STREAM: begin
                if (xfer_s && last_q) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer_s) begin
                    row_d  = nrow_s;
                    col_d  = ncol_s;
                    data_d = mem_q[nrow_s][ncol_s];
                    last_d = (nrow_s == ROW_LAST) && (ncol_s == COL_LAST);
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            data_q  <= {DATA_WIDTH{1'b0}};
            row_q   <= {RW{1'b0}};
            col_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Snapshot buffer has no reset: contents only matter after a capture.
    always_ff @(posedge iclk) begin
        mem_q <= mem_d;
    end

`ifdef GEMM_STREAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    // Running XOR of every transferred word, cleared on capture.
    always_comb begin
        if ((state_q == S_IDLE) && istart) begin
            csum_d = {DATA_WIDTH{1'b0}};
        end else if ((state_q == S_STREAM) && xfer_s) begin
            csum_d = csum_q ^ data_q;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge iclk) begin
        if (irst) begin
            csum_q <= {DATA_WIDTH{1'b0}};
        end else begin
            csum_q <= csum_d;
        end
    end

    assign ochecksum = csum_q;
`else
    assign ochecksum = {DATA_WIDTH{1'b0}};
`endif

    assign ovalid = valid_q;
    assign odata  = data_q;
    assign orow   = row_q;
    assign ocol   = col_q;
    assign olast  = last_q;
    assign obusy  = busy_q;
    assign odone  = done_q;

endmodule

// File: doc/gemm_result_streamer.md
# gemm_result_streamer

Output-side companion to `gemm_top`. On a start pulse it snapshots the full `result_matrix` into an internal buffer, then emits the elements one per beat, row-major, over a valid/ready stream. Each beat carries its row/column index and a last flag. This lets results be drained by a checker, DMA writer or file-dump bench stage without holding the GEMM outputs stable.

## Interface
- `DATA_WIDTH`, 64: element width, same encoding as `gemm_top` results.
- `MATRIX_HEIGHT`, 4: rows in the result matrix.
- `MATRIX_WIDTH`, 4: columns in the result matrix.
- `iclk`  in  1  clock; one clock domain only.
- `irst`  in  1  synchronous, active-high reset.
- `istart`  in  1  capture request; acted on only in IDLE.
- `result_matrix`  in  `[DATA_WIDTH-1:0]` `[0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1]`  GEMM result array, sampled on an accepted `istart`.
- `ovalid`  out  1  `odata` / `orow` / `ocol` / `olast` are valid.
- `iready`  in  1  downstream accepts the beat.
- `odata`  out  DATA_WIDTH  current element.
- `orow`  out  RW = max(1, $clog2(MATRIX_HEIGHT))  row index of `odata`.
- `ocol`  out  CW = max(1, $clog2(MATRIX_WIDTH))  column index of `odata`.
- `olast`  out  1  high on element [H-1][W-1].
- `obusy`  out  1  high while STREAM.
- `odone`  out  1  one-cycle pulse after the last beat is accepted.
- `ochecksum`  out  DATA_WIDTH  checksum of the emitted words (see Configuration).

## Operation
- States: IDLE and STREAM.
- IDLE:
  - `ovalid` = 0 and `obusy` = 0.
  - On `istart` = 1, all H×W elements are copied into the buffer. Row and column counters are cleared to 0, and the state moves to STREAM.
- STREAM:
  - `ovalid` = 1 and `odata` = buf[row][col].
  - A beat is transferred when `ovalid && iready`.
  - On a transfer, `col` increments. At `col == W-1`, `col` wraps to 0 and `row` increments.
  - On the transfer of element [H-1][W-1] (`olast` = 1), the state returns to IDLE and `odone` pulses the next cycle.
- Backpressure: while `ovalid && !iready`, all beat outputs hold stable and the counters do not move.
- `istart` during STREAM is ignored. This includes the final-beat cycle. The buffer is not overwritten.
- Buffer isolation: changes on `result_matrix` after capture have no effect on the stream.
- H = W = 1: a single beat with `olast` = 1; the widths of `orow` and `ocol` stay at 1 bit.
- `olast` is asserted only when `ovalid` = 1.

## Timing
- Reset (`irst` = 1 at a rising edge):
  - State = IDLE, counters = 0.
  - `ovalid`, `olast`, `obusy`, `odone` = 0.
  - `odata`, `orow`, `ocol`, `ochecksum` = 0.
  - The buffer contents are don't-care.
- Reset mid-stream aborts immediately. There is no `odone` pulse, and the next `istart` restarts at [0][0].
- Timing relative to an accepted `istart` at edge N:
  - `ovalid` = 1 and `obusy` = 1 with element [0][0] from edge N+1.
  - Throughput is 1 beat per clock with `iready` held high.
  - 16 beats for 4×4 occupy edges N+1 .. N+16.
- If the last beat transfers at edge M:
  - At M+1: `odone` = 1, `ovalid` = 0, `obusy` = 0, and the state is IDLE.
  - `istart` is accepted again from edge M+1.
- All outputs are registered. There is no combinational path from `iready` to any output.

## Configuration
- Macro `GEMM_STREAM_CHECKSUM_EN`.
- Defined:
  - `ochecksum` is a running XOR of every transferred `odata` word.
  - It is cleared on reset and on an accepted `istart`.
  - It is updated on each transfer, so its final value is valid while `odone` = 1 and held until the next `istart`.
- Undefined: `ochecksum` is tied to 0 and no checksum logic is synthesized.

## Test plan
- Basic stream:
  - Stimulus: `result_matrix[i][j]` = 4*i + j + 1, `iready` = 1, `istart` pulse.
  - Response: 16 consecutive beats, `odata` 1..16, (`orow`, `ocol`) = (0,0)..(3,3), `olast` only on 16, `odone` one cycle after beat 16.
  - With `GEMM_STREAM_CHECKSUM_EN` defined: `ochecksum` = 64'h10 at `odone`.
- Backpressure:
  - Stimulus: `iready` pattern 1,0,0,1 repeating.
  - Response: `odata` is never skipped or duplicated, beat outputs are stable during stalls, the sequence is still 1..16 in order, and `odone` comes after the 16th accepted beat.
- Snapshot isolation:
  - Stimulus: overwrite all `result_matrix` elements with 64'hDEAD one cycle after `istart`.
  - Response: the stream still emits 1..16.
- Start while busy:
  - Stimulus: `istart` pulses at beat 3 and in the last-beat cycle.
  - Response: both are ignored and exactly 16 beats are emitted. An `istart` in the `odone` cycle starts a new 16-beat stream.
- Reset mid-stream:
  - Stimulus: assert `irst` after beat 5 is accepted.
  - Response: next cycle `ovalid` = 0 and `odone` never pulses. A following `istart` streams from [0][0] with `odata` = 1.
- Degenerate size:
  - Stimulus: `MATRIX_HEIGHT` = `MATRIX_WIDTH` = 1, element = 64'h5.
  - Response: one beat with `odata` = 5, `olast` = 1, `orow` = `ocol` = 0, then `odone`.
